// File: rtl/io_port_bridge_pkg.sv
// Shared definitions for the memory-mapped I/O bridge: register offsets,
// STATUS bit positions and the default base address of the I/O window.
package io_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h1001_0000;
    localparam logic [31:0] IO_WINDOW_BYTES = 32'd32;

    // Word offsets within the window (Address[4:2])
    localparam logic [2:0] OFF_PORT_OUT = 3'd0;
    localparam logic [2:0] OFF_PORT_IN  = 3'd1;
    localparam logic [2:0] OFF_STATUS   = 3'd2;
    localparam logic [2:0] OFF_TX_DATA  = 3'd3;
    localparam logic [2:0] OFF_CLEAR    = 3'd4;

    // STATUS register bit indices
    localparam int unsigned ST_TX_FULL     = 0;
    localparam int unsigned ST_TX_EMPTY    = 1;
    localparam int unsigned ST_IN_CHANGED  = 2;
    localparam int unsigned ST_TX_OVERFLOW = 3;

    // True when addr falls inside the 32-byte window starting at base.
    // Unsigned difference avoids overflow when base sits near the top.
    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
        logic [31:0] w_diff;
        w_diff = addr - base;
        return (w_diff < IO_WINDOW_BYTES);
    endfunction

endpackage

// File: rtl/io_port_bridge_if.sv
// Processor load/store bus seen by the I/O bridge.
interface io_port_bridge_if;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        IOSelect;

    modport master (
        output MemWrite, MemRead, Address, WriteData,
        input  ReadData, IOSelect
    );

    modport slave (
        input  MemWrite, MemRead, Address, WriteData,
        output ReadData, IOSelect
    );
endinterface

// File: rtl/io_port_bridge_tx_fifo.sv
// Transmit FIFO: register-array storage, pointers wrap modulo DEPTH.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
// Head output is forced to 0 while empty so reset leaves TxData at 0.
module io_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    output logic             o_full,
    input  logic             i_pop,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; reset discards all contents
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; contents need no reset since the head is masked when empty
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/io_port_bridge.sv
// Memory-mapped I/O bridge: output port register, synchronized input port,
// sticky status flags and a byte transmit FIFO behind a 32-byte window.
// Optional macro IO_EDGE_DETECT_EN adds a third input flop and the
// in_changed sticky flag (STATUS bit2, cleared via CLEAR bit2).
module io_port_bridge
    import io_pkg::*;
#(
    parameter logic [31:0] IO_BASE  = IO_BASE_DEFAULT,
    parameter int unsigned TX_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    io_port_bridge_if.slave   bus,
    input  logic [7:0]        PortIn,
    output logic [31:0]       PortOut,
    output logic [7:0]        TxData,
    output logic              TxValid,
    input  logic              TxReady
);
    logic        w_sel;
    logic [2:0]  w_off;
    logic        w_wr;
    logic        w_tx_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic        w_ovf_set;
    logic        w_clr_ovf;
    logic        w_in_changed;
    logic [31:0] w_status;
    logic [31:0] w_read_data;

    logic [31:0] r_port_out;
    logic [7:0]  r_sync1;
    logic [7:0]  r_sync2;
    logic        r_tx_overflow;

    assign w_sel     = in_window(bus.Address, IO_BASE);
    assign w_off     = bus.Address[4:2];
    assign w_wr      = bus.MemWrite & w_sel;
    assign w_tx_push = w_wr & (w_off == OFF_TX_DATA);
    assign w_pop     = TxValid & TxReady;
    assign w_ovf_set = w_tx_push & w_full & ~w_pop;
    assign w_clr_ovf = w_wr & (w_off == OFF_CLEAR) & bus.WriteData[ST_TX_OVERFLOW];

    io_tx_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_tx_push),
        .i_push_data (bus.WriteData[7:0]),
        .o_full      (w_full),
        .i_pop       (w_pop),
        .o_empty     (w_empty),
        .o_head      (TxData)
    );

    assign TxValid = ~w_empty;
    assign PortOut = r_port_out;

    // Output port register and two-flop input synchronizer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_port_out <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
        end else begin
            if (w_wr && (w_off == OFF_PORT_OUT)) r_port_out <= bus.WriteData;
            r_sync1 <= PortIn;
            r_sync2 <= r_sync1;
        end
    end

    // Sticky overflow flag; a set in the same cycle as a clear wins
    always_ff @(posedge clk) begin
        if (reset) r_tx_overflow <= 1'b0;
        else       r_tx_overflow <= w_ovf_set | (r_tx_overflow & ~w_clr_ovf);
    end

`ifdef IO_EDGE_DETECT_EN
    logic [7:0] r_sync3;
    logic       r_in_changed;
    logic       w_clr_inch;

    assign w_clr_inch   = w_wr & (w_off == OFF_CLEAR) & bus.WriteData[ST_IN_CHANGED];
    assign w_in_changed = r_in_changed;

    // Third stage compares against stage 2; sticky change flag, set wins
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync3      <= '0;
            r_in_changed <= 1'b0;
        end else begin
            r_sync3      <= r_sync2;
            r_in_changed <= (r_sync2 != r_sync3) | (r_in_changed & ~w_clr_inch);
        end
    end
`else
    assign w_in_changed = 1'b0;
`endif

    assign w_status = {28'd0, r_tx_overflow, w_in_changed, w_empty, w_full};

    // Combinational read mux; register state is pre-write during a store
    always_comb begin
        w_read_data = '0;
        if (bus.MemRead && w_sel) begin
            case (w_off)
                OFF_PORT_OUT: w_read_data = r_port_out;
                OFF_PORT_IN:  w_read_data = {24'd0, r_sync2};
                OFF_STATUS:   w_read_data = w_status;
                default:      w_read_data = '0;
            endcase
        end
    end

    assign bus.ReadData = w_read_data;
    assign bus.IOSelect = w_sel;

endmodule

// File: doc/io_port_bridge.md
IO_PORT_BRIDGE -- requirements
Module: io_port_bridge

Interface
REQ-001 Parameters, one per line: name, default, meaning:
  IO_BASE  32'h1001_0000  base address of the 32-byte I/O window.
  TX_DEPTH  4  transmit FIFO depth; power of two, minimum 2.
REQ-002 Ports, one per line: name, direction, width, meaning:
  clk  input  1  single clock; all state updates on its rising edge.
  reset  input  1  synchronous, active-high reset.
  MemWrite  input  1  processor store strobe.
  MemRead  input  1  processor load strobe.
  Address  input  32  processor byte address, taken from the ALU result.
  WriteData  input  32  store data.
  ReadData  output  32  load data.
  IOSelect  output  1  Address lies in [IO_BASE, IO_BASE+0x1F].
  PortIn  input  8  asynchronous external input pins.
  PortOut  output  32  output port register.
  TxData  output  8  FIFO head byte.
  TxValid  output  1  FIFO not empty.
  TxReady  input  1  consumer accepts the head byte when TxValid=1 in the same cycle.

Function
REQ-003 Decode SHALL be combinational: offset = Address[4:2]; Address[1:0] are ignored.
REQ-004 Register map, by offset:
  0: PORT_OUT, read/write.
  1: PORT_IN, read-only; returns the synchronized PortIn, zero-extended.
  2: STATUS, read-only; bit0 tx_full, bit1 tx_empty, bit2 in_changed, bit3 tx_overflow, other bits 0.
  3: TX_DATA, write-only; pushes WriteData[7:0].
  4: CLEAR, write-only; writing 1 to bit2 or bit3 clears the matching sticky bit.
  5..7: reserved; read 0, writes ignored.
REQ-005 ReadData SHALL be combinational, valid in the same cycle as MemRead with IOSelect set; it SHALL be 0 otherwise.
REQ-006 Writes SHALL take effect only when MemWrite=1 and IOSelect=1, at the next rising edge.
REQ-007 If MemRead and MemWrite are asserted together, ReadData SHALL return the pre-write value.
REQ-008 PortIn SHALL pass through a two-flop synchronizer, giving a 2-cycle latency to PORT_IN.
REQ-009 Push accepted: TX_DATA write and (count < TX_DEPTH, or a pop occurs in the same cycle).
REQ-010 Push rejected: TX_DATA write with the FIFO full and no pop. The data SHALL be dropped and tx_overflow set sticky.
REQ-011 A pop SHALL occur when TxValid and TxReady are both 1.
REQ-012 A simultaneous push and pop SHALL leave the count unchanged.
REQ-013 Push into an empty FIFO: TxValid SHALL rise the next cycle. No same-cycle bypass.
REQ-014 FIFO read and write pointers SHALL wrap modulo TX_DEPTH. The count SHALL be $clog2(TX_DEPTH)+1 bits wide.
REQ-015 TxData SHALL be the registered head entry. It SHALL stay stable while TxValid=1 and TxReady=0.
REQ-016 A sticky set and a CLEAR of the same bit in one cycle: set wins.

Reset
REQ-017 When reset=1 at a rising edge, the following SHALL apply next cycle:
  PortOut=0.
  Synchronizer flops = 0.
  FIFO empty: TxValid=0, TxData=0.
  in_changed=0 and tx_overflow=0.
REQ-018 Reset asserted mid-transfer SHALL discard all FIFO contents. No pop SHALL be reported that cycle.

Configuration
REQ-019 Macro IO_EDGE_DETECT_EN:
  Defined: a third flop follows the synchronizer; in_changed is set whenever sync stage 2 differs from stage 3.
  Undefined: the third flop and the in_changed logic are absent; STATUS bit2 reads 0; CLEAR bit2 is ignored.

Structure
REQ-020 Shared package io_pkg SHALL hold the offset constants (OFF_PORT_OUT..OFF_CLEAR), the STATUS bit indices, and the default IO_BASE.
REQ-021 The FIFO SHALL be a sub-module io_tx_fifo, parameterized by width and depth, with push/full/pop/empty handshake.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
  Write 0xDEADBEEF to IO_BASE+0 -> PortOut=0xDEADBEEF next cycle; read of offset 0 returns 0xDEADBEEF the same cycle.
  PortIn 0x00->0x5A -> PORT_IN reads 0x5A after exactly 2 cycles. With IO_EDGE_DETECT_EN: STATUS bit2=1; write 0x4 to CLEAR -> bit2=0.
  TxReady=0; push 0x11,0x22,0x33,0x44,0x55 with TX_DEPTH=4 -> STATUS=0x9 (full, overflow). Then TxReady=1 -> bytes 0x11..0x44 drain in order, followed by tx_empty=1.
  FIFO full with TxReady=1 and a push of 0x66 in the same cycle -> accepted, no overflow, count stays 4.
  Store to IO_BASE+0x20 -> IOSelect=0 and no state changes. Read of offset 6 -> ReadData=0.
  Reset asserted with 3 bytes queued -> TxValid=0, PortOut=0, STATUS=0x2 next cycle.
